// File: rtl/mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SelZero = 3'd0,
    SelP1   = 3'd1,
    SelP2   = 3'd2,
    SelM1   = 3'd3,
    SelM2   = 3'd4
  } booth_sel_e;

  // Radix-4 retires two multiplier bits per cycle over the (DATA_SIZE+2)-bit extended operand.
  function automatic int unsigned iter_count(input int unsigned data_size);
    return data_size / 2 + 1;
  endfunction

endpackage

// File: rtl/add_sub.sv
// Two's-complement adder/subtractor; subtraction inverts b and injects the carry-in.
module add_sub #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             sub,
  output logic [Width-1:0] sum
);

  logic [Width-1:0] b_eff;

  assign b_eff = b ^ {Width{sub}};
  assign sum   = a + b_eff + Width'(sub);

endmodule

// File: rtl/booth_pp_sel.sv
// Booth triplet decode and partial-product mux; negation is completed by the adder carry-in.
module booth_pp_sel
  import mul_pkg::*;
#(
  parameter int unsigned Width = 18
) (
  input  logic [2:0]       triplet,
  input  logic [Width-1:0] mcand,
  output logic [Width+1:0] pp,
  output logic             negate
);

  booth_sel_e       sel;
  logic [Width+1:0] m_ext;

  assign m_ext = {{2{mcand[Width-1]}}, mcand};

  always_comb begin
    sel = SelZero;
    unique case (triplet)
      3'b001, 3'b010: sel = SelP1;
      3'b011:         sel = SelP2;
      3'b100:         sel = SelM2;
      3'b101, 3'b110: sel = SelM1;
      default:        sel = SelZero;
    endcase
  end

  always_comb begin
    pp     = '0;
    negate = 1'b0;
    unique case (sel)
      SelP1: pp = m_ext;
      SelP2: pp = {m_ext[Width:0], 1'b0};
      SelM1: begin
        pp     = m_ext;
        negate = 1'b1;
      end
      SelM2: begin
        pp     = {m_ext[Width:0], 1'b0};
        negate = 1'b1;
      end
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/d_ff_async_en.sv
// Enabled register with asynchronous active-low clear.
module d_ff_async_en #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mul_booth_fsm.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes on operands and result.
module mul_booth_fsm
  import mul_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ID_SIZE   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_SIZE-1:0]   a_in,
  input  logic [DATA_SIZE-1:0]   b_in,
  input  logic                   signed_in,
  input  logic [ID_SIZE-1:0]     id_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*DATA_SIZE-1:0] result,
  output logic [ID_SIZE-1:0]     id_out,
  output logic                   busy
);

  localparam int unsigned W     = DATA_SIZE + 2;
  localparam int unsigned AccW  = W + 2;
  localparam int unsigned N     = iter_count(DATA_SIZE);
  localparam int unsigned CntW  = $clog2(N) + 1;

  state_e            state_q;
  logic [AccW-1:0]   acc_q, acc_nxt, pp, sum;
  logic [W:0]        mplr_q, mplr_nxt;
  logic [W-1:0]      mcand_q, ext_a, ext_b;
  logic [CntW-1:0]   cnt_q;
  logic [ID_SIZE-1:0] id_q;
  logic              negate, accept, last;

  assign in_ready  = (state_q == StIdle);
  assign res_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign accept    = in_valid & in_ready;
  assign last      = (state_q == StCalc) && (cnt_q == CntW'(N - 1));

  assign ext_a = {{2{signed_in & a_in[DATA_SIZE-1]}}, a_in};
  assign ext_b = {{2{signed_in & b_in[DATA_SIZE-1]}}, b_in};

  booth_pp_sel #(
    .Width (W)
  ) u_pp_sel (
    .triplet (mplr_q[2:0]),
    .mcand   (mcand_q),
    .pp      (pp),
    .negate  (negate)
  );

  add_sub #(
    .Width (AccW)
  ) u_add_sub (
    .a   (acc_q),
    .b   (pp),
    .sub (negate),
    .sum (sum)
  );

  // Arithmetic shift of the combined {acc, multiplier} register by two.
  assign acc_nxt  = {{2{sum[AccW-1]}}, sum[AccW-1:2]};
  assign mplr_nxt = {sum[1:0], mplr_q[W:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StCalc;
            mcand_q <= ext_a;
            acc_q   <= '0;
            mplr_q  <= {ext_b, 1'b0};
            cnt_q   <= '0;
          end
        end
        StCalc: begin
          acc_q  <= acc_nxt;
          mplr_q <= mplr_nxt;
          cnt_q  <= cnt_q + CntW'(1);
          if (last) state_q <= StDone;
        end
        StDone: begin
          if (res_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  d_ff_async_en #(
    .Width (ID_SIZE)
  ) u_id_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .d     (id_in),
    .q     (id_q)
  );

  // Bit 0 of the multiplier register is the Booth guard bit, not a product bit.
  d_ff_async_en #(
    .Width (2 * DATA_SIZE)
  ) u_result_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (last),
    .d     ({acc_nxt[DATA_SIZE-3:0], mplr_nxt[W:1]}),
    .q     (result)
  );

  d_ff_async_en #(
    .Width (ID_SIZE)
  ) u_id_out_q (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (last),
    .d     (id_q),
    .q     (id_out)
  );

endmodule

// File: tb/tb_mul_booth_fsm.sv
// Self-checking bench for mul_booth_fsm against a plain-arithmetic product model.
module tb_mul_booth_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_in, b_in;
  logic        signed_in;
  logic [3:0]  id_in;
  logic        in_valid, in_ready, res_valid, res_ready, busy;
  logic [31:0] result;
  logic [3:0]  id_out;

  int  errors = 0;
  int  checks = 0;
  time last_acc = 0;

  always #5 clk = ~clk;

  mul_booth_fsm #(
    .DATA_SIZE (16),
    .ID_SIZE   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .signed_in (signed_in),
    .id_in     (id_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .id_out    (id_out),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    longint      sa, sb;
    logic [63:0] p;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[31:0];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("res_valid_wait", res_valid, 1);
  endtask

  // Leaves in_valid high with scrambled operands so late input changes are exercised.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [3:0] id, input bit chk_lat, input bit chk_period,
                        input string tag);
    int          lat;
    time         t_acc;
    logic [31:0] exp;
    exp       = ref_mul(a, b, s);
    a_in      = a;
    b_in      = b;
    signed_in = s;
    id_in     = id;
    in_valid  = 1'b1;
    res_ready = 1'b1;
    wait_ready();
    @(posedge clk);
    t_acc = $time;
    #1;
    if (chk_period) check({tag, "_period"}, (t_acc - last_acc) / 10, 11);
    last_acc  = t_acc;
    a_in      = 16'($urandom);
    b_in      = 16'($urandom);
    signed_in = ~s;
    id_in     = ~id;
    wait_result(lat);
    if (chk_lat) check({tag, "_latency"}, lat, 9);
    check({tag, "_result"}, result, exp);
    check({tag, "_id"}, id_out, id);
    check({tag, "_in_ready_done"}, in_ready, 0);
  endtask

  initial begin
    int          lat;
    logic [31:0] exp_bp;

    rst_n     = 1'b0;
    a_in      = '0;
    b_in      = '0;
    signed_in = 1'b0;
    id_in     = '0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_id_out", id_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd3, 16'd5, 1'b0, 4'h7, 1, 0, "u3x5");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 4'h1, 1, 0, "uffff");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 4'h2, 1, 0, "sm1");
    run_op(16'h8000, 16'h8000, 1'b1, 4'h3, 1, 0, "s8000sq");
    run_op(16'h8000, 16'h0002, 1'b1, 4'h4, 1, 0, "s8000x2");

    // Backpressure with a second operation waiting on the input side.
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_bp    = ref_mul(16'h1234, 16'h0056, 1'b0);
    a_in      = 16'h1234;
    b_in      = 16'h0056;
    signed_in = 1'b0;
    id_in     = 4'hA;
    in_valid  = 1'b1;
    res_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    a_in  = 16'd7;
    b_in  = 16'd9;
    id_in = 4'h5;
    wait_result(lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_result", result, exp_bp);
      check("bp_id", id_out, 4'hA);
      check("bp_in_ready", in_ready, 0);
      check("bp_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", res_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_hold_result", result, exp_bp);
    @(posedge clk); #1;
    check("bp_next_accept", busy, 1);
    in_valid = 1'b0;
    wait_result(lat);
    check("bp_next_result", result, 32'd63);
    check("bp_next_id", id_out, 4'h5);

    // Back-to-back random traffic.
    for (int i = 0; i < 100; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 4'(i), 0, i > 0, "rnd");
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset during the fourth CALC cycle.
    a_in      = 16'h00FF;
    b_in      = 16'h0101;
    signed_in = 1'b0;
    id_in     = 4'hC;
    in_valid  = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_id", id_out, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_ghost", res_valid, 0);
    run_op(16'hFFFE, 16'h0003, 1'b1, 4'h9, 1, 0, "post_rst");
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
